// File: rtl/adder_10_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adder_10_pkg
// Purpose : Shared constants, the default-width pipeline stage record and a
//           result-width helper for the adder_10 slice.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package adder_10_pkg;

  localparam int W_DEFAULT   = 2;
  localparam int LATENCY_MAX = 3;

  // One pipeline stage as seen at the default operand width.
  typedef struct packed {
    logic                 valid;
    logic [W_DEFAULT:0]   sum;
  } stage_rec_t;

  // A W-bit add with carry-in needs one extra bit to hold the carry-out.
  function automatic int sum_width(input int w);
    return w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_10_stage.sv
`default_nettype none
// ============================================================================
// Module  : adder_10_stage
// Purpose : One resettable pipeline register. The valid bit is always
//           captured; the data bit-field only loads when valid is high, so a
//           bubble leaves the previous data untouched.
// Ports   : clk       in   clock, rising edge
//           rst_n     in   asynchronous active-low reset
//           in_valid  in   stage input valid
//           in_data   in   [DW-1:0] stage input data
//           out_valid out  registered valid
//           out_data  out  [DW-1:0] registered (enabled) data
// Revision: 1.0  initial release
// ============================================================================
module adder_10_stage
  import adder_10_pkg::*;
#(
  parameter int DW = sum_width(W_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      // Enable on valid keeps X on idle operands out of the data path.
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adder_10_unit.sv
`default_nettype none
// ============================================================================
// Module  : adder_10_unit
// Purpose : Registered small-width adder slice, sum = a + b + cin with the
//           carry-out kept in sum[W]. Result appears LATENCY cycles after
//           the operands are captured, qualified by out_valid.
// Config  : ADDER_10_APPROX_EN - when defined, cin is ignored (sum = a + b).
// Ports   : clk       in   clock, rising edge
//           rst_n     in   asynchronous active-low reset
//           in_valid  in   operands valid this cycle
//           a         in   [W-1:0] operand A
//           b         in   [W-1:0] operand B
//           cin       in   carry-in
//           out_valid out  sum valid
//           sum       out  [W:0] result, sum[W] is the carry-out
// Revision: 1.0  initial release
// ============================================================================
module adder_10_unit
  import adder_10_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  output logic [W:0]   sum
);

  localparam int SW = sum_width(W);

  // Configuration guard: zero-latency would need a combinational bypass
  // that this slice does not provide.
  if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("adder_10_unit: LATENCY must be in 1..%0d", LATENCY_MAX);
  end
  if (W < 1) begin : g_bad_width
    $error("adder_10_unit: W must be >= 1");
  end

  logic cin_eff;
`ifdef ADDER_10_APPROX_EN
  // Approximate mode drops the carry-in; the port stays for drop-in use.
  logic unused_cin;
  assign unused_cin = cin;
  assign cin_eff    = 1'b0;
`else
  assign cin_eff    = cin;
`endif

  // Zero-extend before adding so the carry-out lands in the MSB.
  logic [SW-1:0] sum_comb;
  assign sum_comb = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin_eff};

  logic [LATENCY:0] vld_chain;
  logic [SW-1:0]    data_chain [LATENCY+1];

  assign vld_chain[0]  = in_valid;
  assign data_chain[0] = sum_comb;

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    adder_10_stage #(
      .DW (SW)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld_chain[k]),
      .in_data   (data_chain[k]),
      .out_valid (vld_chain[k+1]),
      .out_data  (data_chain[k+1])
    );
  end

  assign out_valid = vld_chain[LATENCY];
  assign sum       = data_chain[LATENCY];

endmodule
`default_nettype wire

// File: tb/tb_adder_10_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_adder_10_unit
// Purpose : Self-checking bench for adder_10_unit. Three instances
//           (LATENCY 1, 2, 3) share one stimulus stream; each has its own
//           scoreboard queue of expected results with their due cycle.
// Revision: 1.0  initial release
// ============================================================================
module tb_adder_10_unit;
  import adder_10_pkg::*;

  typedef struct {
    stage_rec_t rec;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] a;
  logic [1:0] b;
  logic       cin;

  logic       ov [3];
  logic [2:0] sm [3];

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [2:0] model(input logic [1:0] x, input logic [1:0] y, input logic c);
    int s;
`ifdef ADDER_10_APPROX_EN
    s = int'(x) + int'(y);
`else
    s = int'(x) + int'(y) + int'(c);
`endif
    return 3'(s);
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_lane
    localparam int L = k + 1;
    exp_t       q[$];
    exp_t       e;
    logic [2:0] last = 3'd0;

    adder_10_unit #(
      .W       (2),
      .LATENCY (L)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (ov[k]),
      .sum       (sm[k])
    );

    // Scoreboard push at the capture edge; cyc still holds its pre-edge value.
    always @(posedge clk) begin
      if (rst_n === 1'b1 && in_valid === 1'b1) begin
        e.rec.valid = 1'b1;
        e.rec.sum   = model(a, b, cin);
        e.due       = cyc + L;
        q.push_back(e);
      end
    end

    always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
        check($sformatf("L%0d reset out_valid", L), 32'(ov[k]), 32'd0);
        check($sformatf("L%0d reset sum", L), 32'(sm[k]), 32'd0);
        q.delete();
        last <= 3'd0;
      end else if (ov[k] === 1'b1) begin
        if (q.size() == 0) begin
          check($sformatf("L%0d spurious out_valid", L), 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check($sformatf("L%0d latency", L), 32'(cyc), 32'(e.due));
          check($sformatf("L%0d sum", L), 32'(sm[k]), 32'(e.rec.sum));
          last <= e.rec.sum;
        end
      end else begin
        check($sformatf("L%0d out_valid", L), 32'(ov[k]), 32'd0);
        check($sformatf("L%0d held sum", L), 32'(sm[k]), 32'(last));
        if (q.size() > 0 && q[0].due <= cyc) begin
          check($sformatf("L%0d missing result", L), 32'd0, 32'd1);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic [1:0] x, input logic [1:0] y, input logic c);
    @(negedge clk);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a        = 'x;
      b        = 'x;
      cin      = 1'bx;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s out_valid[%0d]", tag, k), 32'(ov[k]), 32'd0);
      check($sformatf("%s sum[%0d]", tag, k), 32'(sm[k]), 32'd0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    cin      = 1'bx;
    #1;
    check_all_zero("power-on reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Exhaustive {a,b,cin}, back to back.
    for (int i = 0; i < 32; i++) begin
      drive(i[4:3], i[2:1], i[0]);
    end
    idle(5);

    // valid, idle, valid.
    drive(2'd1, 2'd2, 1'b0);
    idle(1);
    drive(2'd3, 2'd0, 1'b1);
    idle(5);

    // Single op for the latency sweep.
    drive(2'd3, 2'd1, 1'b0);
    idle(5);

    // Reset with two operations in flight in the deepest pipe.
    drive(2'd3, 2'd3, 1'b1);
    drive(2'd2, 2'd1, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    cin      = 1'bx;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(6);

    // A few random operations with gaps.
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        idle(1);
      end else begin
        drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
